// File: rtl/fifo_uart_tx.sv
// Serial transmitter that pops words from an upstream FIFO and sends them as
// start / WIDTH data bits (LSB first) / stop frames on a registered tx line.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    baud;
  logic [NW-1:0]    bit_cnt;
  logic             baud_end, last_bit;

  assign baud_end = (baud == BW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_cnt == NW'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    fifo_ren = 1'b0;
    busy     = (state != IDLE);
    done     = (state == STOP) && baud_end;
    case (state)
      IDLE: begin
        // Pop is suppressed during reset so a reset cycle never loses a word.
        if (enable && !fifo_empty && !rst) begin
          fifo_ren = 1'b1;
          state_nx = START;
        end
      end
      START:   if (baud_end) state_nx = DATA;
      DATA:    if (baud_end && last_bit) state_nx = STOP;
      STOP:    if (baud_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      baud    <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      // Baud counter restarts on every state change and on every data bit boundary.
      if (state == IDLE || state_nx != state || (state == DATA && baud_end))
        baud <= '0;
      else
        baud <= baud + 1'b1;

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (fifo_ren) begin
            shreg   <= fifo_rdata;
            bit_cnt <= '0;
            tx      <= 1'b0;
          end
        end
        START: if (baud_end) tx <= shreg[0];
        DATA: begin
          if (baud_end) begin
            if (last_bit) begin
              tx <= 1'b1;
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP:    tx <= 1'b1;
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeds the DUT, a tx decoder checks every
// frame against a queue of expected words, and line invariants run every cycle.
module tb_fifo_uart_tx;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;

  logic             clk, rst, enable, fifo_empty, fifo_ren, tx, busy, done;
  logic [WIDTH-1:0] fifo_rdata;

  fifo_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .fifo_ren(fifo_ren), .tx(tx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    else passed++;
  endtask

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];

  function automatic void upd();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  task automatic push(input logic [WIDTH-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    upd();
  endtask

  // Monitor state
  int cycle = 0, pops = 0, last_pop = -100, last_done = -100, done_cnt = 0;
  int frames = 0, aborts = 0, mon_cyc = 0, low_run = 0, last_low_run = 0;
  bit in_frame = 0, pop_pend = 0;
  logic [WIDTH-1:0] rx;

  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      pop_pend = 0;
      void'(fifo_q.pop_front());
      upd();
    end
  end

  always @(negedge clk) begin
    cycle++;
    chk("ren_empty", int'(fifo_ren && fifo_empty), 0);
    chk("ren_busy", int'(fifo_ren && busy), 0);
    chk("ren_rst", int'(fifo_ren && rst), 0);
    chk("idle_tx", int'(!busy && !tx), 0);
    if (fifo_ren) begin pop_pend = 1; pops++; last_pop = cycle; end
    if (done) begin done_cnt++; last_done = cycle; end
    if (!tx) low_run++;
    else begin
      if (low_run > 0) last_low_run = low_run;
      low_run = 0;
    end
    if (in_frame) begin
      if (rst) begin
        in_frame = 0;
        aborts++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        mon_cyc++;
        if (mon_cyc == 2) chk("start_bit", int'(tx), 0);
        if (mon_cyc >= 6 && mon_cyc <= 34 && (mon_cyc - 6) % CPB == 0)
          rx[(mon_cyc - 6) / CPB] = tx;
        if (mon_cyc == 38) begin
          chk("stop_bit", int'(tx), 1);
          chk("busy_stop", int'(busy), 1);
          if (exp_q.size() == 0) chk("exp_empty", 0, 1);
          else chk("byte", int'(rx), int'(exp_q.pop_front()));
        end
        if (mon_cyc == 39) begin
          chk("done_end", int'(done), 1);
          in_frame = 0;
          frames++;
        end
      end
    end else if (!tx && !rst) begin
      in_frame = 1;
      mon_cyc  = 0;
      chk("start_lat", cycle - last_pop, 1);
      chk("busy_start", int'(busy), 1);
    end
  end

  task automatic wait_pops(input int n);
    int k = 0;
    while (pops < n && k < 3000) begin @(negedge clk); #1; k++; end
    chk("pop_timeout", int'(pops >= n), 1);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames < n && k < 3000) begin @(negedge clk); #1; k++; end
    chk("frame_timeout", int'(frames >= n), 1);
  endtask

  initial begin
    int p0, t1, k;
    rst = 1'b1; enable = 1'b1; upd();
    push(8'hA5);
    // Reset state with a non-empty FIFO and enable high
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_ren", int'(fifo_ren), 0);
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // Single word 0xA5
    wait_frames(1);
    chk("single_pops", pops, 1);
    chk("done_lat", last_done - last_pop, 40);
    chk("single_done", done_cnt, 1);

    // Back-to-back 0x00 then 0xFF
    @(posedge clk); #1;
    p0 = pops;
    push(8'h00); push(8'hFF);
    wait_pops(p0 + 1);
    t1 = last_pop;
    wait_pops(p0 + 2);
    chk("b2b_period", last_pop - t1, 41);
    chk("b2b_low_run", last_low_run, 36);
    wait_frames(3);

    // Empty FIFO
    p0 = pops;
    repeat (100) begin
      @(negedge clk); #1;
      chk("empty_ren", int'(fifo_ren), 0);
      chk("empty_busy", int'(busy), 0);
    end
    chk("empty_pops", pops, p0);

    // Enable dropped mid-frame
    @(posedge clk); #1;
    p0 = pops;
    push(8'h3C); push(8'h55);
    wait_pops(p0 + 1);
    repeat (10) @(posedge clk);
    #1 enable = 1'b0;
    wait_frames(4);
    repeat (100) @(negedge clk);
    #1;
    chk("gate_pops", pops, p0 + 1);
    chk("gate_left", fifo_q.size(), 1);
    fifo_q.delete(); upd();
    void'(exp_q.pop_back());

    // Reset during data bit 3
    push(8'h96); push(8'h5A);
    @(posedge clk); #1 enable = 1'b1;
    k = 0;
    while (!(in_frame && mon_cyc == 17) && k < 3000) begin @(negedge clk); #1; k++; end
    chk("bit3_timeout", int'(in_frame && mon_cyc == 17), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ren", int'(fifo_ren), 1);
    wait_frames(5);

    repeat (5) @(negedge clk);
    #1;
    chk("aborts", aborts, 1);
    chk("exp_drained", exp_q.size(), 0);
    chk("done_frames", done_cnt, frames);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per frame (and FIFO data width); legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal value >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  permits the start of new frames.
REQ-006 SHALL have port fifo_rdata  input  WIDTH  head-of-FIFO data, valid whenever fifo_empty is low.
REQ-007 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port fifo_ren  output  1  one-cycle pop strobe to the upstream FIFO.
REQ-009 SHALL have port tx  output  WIDTH-independent 1  serial line, 8N1-style framing, idle high.
REQ-010 SHALL have port busy  output  1  high whenever a frame is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; encoding is free.
REQ-013 In IDLE, fifo_ren SHALL equal enable && !fifo_empty (combinational from state and inputs); at that clock edge the block SHALL capture fifo_rdata into a WIDTH-bit shift register and move to START.
REQ-014 fifo_ren SHALL never be high while fifo_empty is high, and never outside IDLE.
REQ-015 tx SHALL be registered: 1 in IDLE, 0 in START, the current shift-register LSB in DATA, 1 in STOP.
REQ-016 START, each DATA bit, and STOP SHALL each last exactly CLKS_PER_BIT cycles, timed by a baud counter of width $clog2(CLKS_PER_BIT) that clears on every state or bit change.
REQ-017 DATA SHALL send WIDTH bits LSB first; a bit counter of width $clog2(WIDTH)+1 SHALL track the bits and DATA SHALL exit to STOP after bit WIDTH-1.
REQ-018 After STOP the FSM SHALL return to IDLE for at least one cycle, so continuous traffic has a frame period of (WIDTH+2)*CLKS_PER_BIT+1 cycles.
REQ-019 tx SHALL fall on the cycle after the fifo_ren cycle, giving a latency of 1 cycle from the pop to the start bit.
REQ-020 busy SHALL be high in START, DATA, STOP and low in IDLE.
REQ-021 Deasserting enable mid-frame SHALL NOT truncate the frame; it SHALL only block the next pop.
REQ-022 Changes of fifo_rdata after capture SHALL NOT affect the frame in flight.

Reset
REQ-023 While rst is high at a clock edge, the block SHALL enter IDLE and clear the shift register, baud counter and bit counter; tx=1, busy=0, done=0 from the next cycle.
REQ-024 fifo_ren SHALL be 0 during any cycle in which rst is high, including IDLE with a non-empty FIFO.
REQ-025 Reset mid-frame SHALL abort the frame immediately (tx returns high next cycle), and the aborted byte SHALL NOT be re-read.

Verification (WIDTH=8, CLKS_PER_BIT=4)
REQ-026 Single byte: FIFO holds 0xA5, enable=1 -> one fifo_ren pulse; tx = 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles (40 cycles total); done pulses once at cycle 40 after the pop.
REQ-027 Back-to-back: FIFO holds 0x00 then 0xFF -> second fifo_ren exactly 41 cycles after the first; tx shows 36 cycles low (start bit plus 8 zero bits), then the stop bit, one idle cycle, the second start bit, and 8 one bits.
REQ-028 Empty FIFO: fifo_empty=1 and enable=1 for 100 cycles -> fifo_ren=0, tx=1, busy=0 throughout.
REQ-029 Enable gating: enable is dropped 10 cycles into the frame for 0x3C -> the full 0x3C frame still completes, then no further pops occur while enable=0 even though fifo_empty=0.
REQ-030 Reset mid-frame: rst is asserted for 1 cycle during DATA bit 3 -> the next cycle shows tx=1, busy=0 and the FSM in IDLE; with enable=1 and a non-empty FIFO, fifo_ren rises on the first cycle after rst falls.
REQ-031 The bench SHALL check these invariants every cycle: no fifo_ren while fifo_empty; at most one fifo_ren per frame; tx=1 whenever busy=0.
